// File: rtl/gpu_mac_pkg.sv
// Shared encodings and helpers for the GPU/DSP multiply / multiply-accumulate pipe.
package gpu_mac_pkg;

  localparam int unsigned PROD_W    = 32;
  localparam int unsigned MAX_ACC_W = 40;

  typedef enum logic [1:0] {
    MAC_OP_MULT   = 2'b00,
    MAC_OP_MAC    = 2'b01,
    MAC_OP_RESMAC = 2'b10,
    MAC_OP_CLR    = 2'b11
  } mac_op_e;

  // Set when the guard bits above bit 31 are not a plain sign extension of bit 31.
  function automatic logic guard_ovf(input logic [MAX_ACC_W-1:0] acc, input int unsigned acc_w);
    logic ovf;
    ovf = 1'b0;
    for (int unsigned i = PROD_W; i < MAX_ACC_W; i++) begin
      if (i < acc_w && acc[i] != acc[PROD_W-1]) ovf = 1'b1;
    end
    return ovf;
  endfunction

endpackage

// File: rtl/gpu_mac_mul16.sv
// First pipe stage: registered 16x16 signed/unsigned multiply, product extended to ACC_W.
module gpu_mac_mul16
  import gpu_mac_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic             i_signed,
  input  logic [15:0]      i_a,
  input  logic [15:0]      i_b,
  output logic             o_valid,
  output logic [1:0]       o_op,
  output logic [ACC_W-1:0] o_prod
);

  logic [PROD_W-1:0] w_prod_s;
  logic [PROD_W-1:0] w_prod_u;
  logic [ACC_W-1:0]  w_prod_ext;
  logic              r_valid;
  logic [1:0]        r_op;
  logic [ACC_W-1:0]  r_prod;

  // Low 32 bits of the sign-extended operands' product are the exact signed product.
  assign w_prod_s = {{16{i_a[15]}}, i_a} * {{16{i_b[15]}}, i_b};
  assign w_prod_u = {16'b0, i_a} * {16'b0, i_b};

  always_comb begin
    w_prod_ext = '0;
    w_prod_ext[PROD_W-1:0] = i_signed ? w_prod_s : w_prod_u;
    for (int unsigned i = PROD_W; i < ACC_W; i++) begin
      w_prod_ext[i] = i_signed & w_prod_s[PROD_W-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_op    <= 2'b00;
      r_prod  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_op   <= i_op;
        r_prod <= w_prod_ext;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_prod  = r_prod;

endmodule

// File: rtl/gpu_mac_pipe.sv
// Two-stage multiply / multiply-accumulate pipe feeding the result saturator.
module gpu_mac_pipe
  import gpu_mac_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_signed,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_n,
  output logic        out_z,
  output logic        busy
);

  logic                 w_s1_valid;
  logic [1:0]           w_s1_op;
  logic [ACC_W-1:0]     w_s1_prod;
  logic                 r_s2_valid;
  mac_op_e              r_s2_op;
  logic [ACC_W-1:0]     r_s2_prod;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     w_acc_next;
  logic [ACC_W-1:0]     w_res;
  logic [MAX_ACC_W-1:0] w_res_wide;
  logic                 w_s2_emit;
  logic                 w_stall;
  logic                 r_out_valid;
  logic [31:0]          r_out_data;
  logic                 r_out_ovf;
  logic                 r_out_n;
  logic                 r_out_z;

  assign w_s2_emit = r_s2_valid & (r_s2_op == MAC_OP_MULT || r_s2_op == MAC_OP_RESMAC);
  // Only an emitting op that would overwrite an unretired beat blocks the pipe.
  assign w_stall   = r_out_valid & ~out_ready & w_s2_emit;

  gpu_mac_mul16 #(
    .ACC_W(ACC_W)
  ) u_mul16 (
    .i_clk   (sys_clk),
    .i_rst_n (resetl),
    .i_en    (~w_stall),
    .i_valid (in_valid),
    .i_op    (in_op),
    .i_signed(in_signed),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_valid (w_s1_valid),
    .o_op    (w_s1_op),
    .o_prod  (w_s1_prod)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_s2_valid <= 1'b0;
      r_s2_op    <= MAC_OP_MULT;
      r_s2_prod  <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_s2_op   <= mac_op_e'(w_s1_op);
        r_s2_prod <= w_s1_prod;
      end
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    unique case (r_s2_op)
      MAC_OP_MULT:   w_acc_next = r_s2_prod;
      MAC_OP_MAC:    w_acc_next = r_acc + r_s2_prod;
      MAC_OP_RESMAC: w_acc_next = r_acc;
      MAC_OP_CLR:    w_acc_next = '0;
    endcase
  end

  always_comb begin
    w_res      = (r_s2_op == MAC_OP_RESMAC) ? r_acc : r_s2_prod;
    w_res_wide = '0;
    w_res_wide[ACC_W-1:0] = w_res;
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_n     <= 1'b0;
      r_out_z     <= 1'b0;
    end else begin
      if (r_s2_valid && !w_stall) r_acc <= w_acc_next;
      if (w_s2_emit && !w_stall) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res[31:0];
        r_out_ovf   <= guard_ovf(w_res_wide, ACC_W);
        r_out_n     <= w_res[31];
        r_out_z     <= (w_res[31:0] == 32'h0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_n     = r_out_n;
  assign out_z     = r_out_z;
  assign busy      = w_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_gpu_mac_pipe.sv
// Randomised bench for gpu_mac_pipe (ACC_W=40) against an arithmetic accumulator model.
module tb_gpu_mac_pipe;

  localparam int unsigned ACC_W = 40;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MAC = 2'b01, OP_RESMAC = 2'b10, OP_CLR = 2'b11;

  logic        sys_clk, resetl, in_valid, in_ready, in_signed;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_ovf, out_n, out_z, busy;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rdy = 0;
  logic [ACC_W-1:0] m_acc;
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];

  gpu_mac_pipe #(.ACC_W(ACC_W)) dut (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_signed(in_signed),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_n    (out_n),
    .out_z    (out_z),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Beats retire at the next rising edge when valid & ready are seen here.
  always @(negedge sys_clk)
    if (resetl && out_valid && out_ready) obs_q.push_back({out_ovf, out_n, out_z, out_data});

  always @(posedge sys_clk)
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end

  // Expected beat {ovf, n, z, data} from an ACC_W-bit two's complement value.
  function automatic logic [34:0] beat(input logic [ACC_W-1:0] v);
    longint sv;
    logic ovf;
    logic [31:0] d;
    sv = longint'(v);
    if (v[ACC_W-1]) sv = sv - (longint'(1) << ACC_W);
    ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    d = v[31:0];
    return {ovf, d[31], d == 32'h0, d};
  endfunction

  task automatic model(input logic [1:0] op, input logic sgn, input logic [15:0] a, b);
    longint p;
    logic [63:0] pu;
    logic [ACC_W-1:0] e;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'(a) * longint'(b);
    pu = p;
    e  = pu[ACC_W-1:0];
    case (op)
      OP_MULT:   begin m_acc = e; exp_q.push_back(beat(e)); end
      OP_MAC:    m_acc = m_acc + e;
      OP_RESMAC: exp_q.push_back(beat(m_acc));
      default:   m_acc = '0;
    endcase
  endtask

  // Present one op, hold it until accepted, return one tick after the accept edge.
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [15:0] a, b);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_signed = sgn; in_a = a; in_b = b;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge sys_clk);
      if (in_ready) begin
        model(op, sgn, a, b);
        done = 1;
      end
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0; in_op = 2'($urandom); in_signed = 1'($urandom);
    in_a = 16'($urandom); in_b = 16'($urandom);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0 for op %0d", op);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (!busy && !out_valid && exp_q.size() == obs_q.size()) break;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_signed = 1'b0; in_a = '0; in_b = '0; m_acc = '0;
    #3;
    n_checks++;
    if ({out_valid, busy, out_data, out_ovf, out_n, out_z} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b busy=%b d=%h o=%b n=%b z=%b required all 0",
               out_valid, busy, out_data, out_ovf, out_n, out_z);
    end
    repeat (2) @(posedge sys_clk);
    #1 resetl = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_mult_latency();
    issue(OP_MULT, 1'b0, 16'h0003, 16'h0004);
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL latency_early_c%0d: out_valid got %b required 0", c, out_valid);
      end
      @(posedge sys_clk); #1;
    end
    n_checks++;
    if ({out_valid, out_data, out_n, out_z, out_ovf} !== {1'b1, 32'h0000000C, 3'b000}) begin
      n_fail++;
      $display("FAIL latency_beat: got v=%b d=%h n=%b z=%b o=%b required v=1 d=0000000c flags 0",
               out_valid, out_data, out_n, out_z, out_ovf);
    end
    drain();
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_signed_resmac();
    issue(OP_MULT, 1'b1, 16'hFFFF, 16'h0002);
    issue(OP_RESMAC, 1'b0, 16'h0, 16'h0);
    drain();
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL sresmac_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_q[i][33:0] !== {2'b10, 32'hFFFFFFFE}) begin
          n_fail++; $display("FAIL sresmac_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mac_overflow();
    issue(OP_CLR, 1'b0, 16'h1234, 16'h5678);
    repeat (3) issue(OP_MAC, 1'b1, 16'h7FFF, 16'h7FFF);
    issue(OP_RESMAC, 1'b0, 16'h0, 16'h0);
    drain();
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL macovf_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_q[0] || obs_q[0] !== {3'b110, 32'hBFFD0003}) begin
        n_fail++; $display("FAIL macovf_beat: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(OP_MULT, 1'b0, 16'd2, 16'd3);
    issue(OP_MULT, 1'b0, 16'd5, 16'd5);
    @(posedge sys_clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({in_ready, out_valid, out_data} !== {2'b01, 32'h6}) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got rdy=%b v=%b d=%h required rdy=0 v=1 d=00000006",
                 c, in_ready, out_valid, out_data);
      end
      @(posedge sys_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h19}) begin
      n_fail++; $display("FAIL bp_next: got v=%b d=%h required v=1 d=00000019", out_valid, out_data);
    end
    drain();
    n_checks++;
    if (obs_q.size() != 2 || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d beats required 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr_z();
    issue(OP_MAC, 1'b0, 16'd9, 16'd9);
    issue(OP_CLR, 1'b0, 16'd1, 16'd1);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL clr_noemit_c%0d: out_valid got %b required 0", c, out_valid);
      end
      @(posedge sys_clk); #1;
    end
    issue(OP_RESMAC, 1'b1, 16'hFFFF, 16'hFFFF);
    drain();
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]
        || obs_q[0] !== {3'b001, 32'h0}) begin
      n_fail++;
      $display("FAIL clr_resmac: got %0d beats first %h required 1 beat 100000000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 35'h0);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    rand_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_a = 16'($urandom); in_op = 2'($urandom);
        @(posedge sys_clk); #1;
      end
      a = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      issue(2'($urandom), 1'($urandom), a, b);
    end
    rand_rdy = 0;
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    issue(OP_MULT, 1'b0, 16'd7, 16'd9);
    issue(OP_MULT, 1'b1, 16'hFFF0, 16'd3);
    issue(OP_MAC, 1'b0, 16'd100, 16'd100);
    @(posedge sys_clk); #2;
    resetl = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, busy, out_data, out_ovf, out_n, out_z, in_ready} !== {37'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL midop_reset: got v=%b busy=%b d=%h o=%b n=%b z=%b rdy=%b required 0s rdy=1",
               out_valid, busy, out_data, out_ovf, out_n, out_z, in_ready);
    end
    exp_q.delete(); obs_q.delete(); m_acc = '0;
    @(posedge sys_clk); #1;
    resetl = 1'b1; out_ready = 1'b1;
    issue(OP_RESMAC, 1'b0, 16'h0, 16'h0);
    drain();
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]
        || obs_q[0] !== {3'b001, 32'h0}) begin
      n_fail++;
      $display("FAIL midop_resmac: got %0d beats first %h required 1 beat 100000000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 35'h0);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_mult_latency();
    test_signed_resmac();
    test_mac_overflow();
    test_backpressure();
    test_clr_z();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
